// File: rtl/multi_stepctl.sv
// N-channel closed-loop step controller: PWM-driven motors run until each counts its target encoder ticks.
// Optional lockstep throttling of leading channels is enabled by defining STEPCTL_SYNC_EN.
module multi_stepctl #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PWM_W      = 16,
  parameter int unsigned PWM_PERIOD = 10000,
  parameter int unsigned SYNC_TOL   = 4
) (
  input  logic                   WF_CLK,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NCH*CNT_W-1:0]   target,
  input  logic [NCH*PWM_W-1:0]   duty,
  input  logic [NCH-1:0]         dir_in,
  input  logic [NCH-1:0]         encdr,
  output logic [NCH-1:0]         pwm,
  output logic [NCH-1:0]         en,
  output logic [NCH-1:0]         dir,
  output logic [NCH*CNT_W-1:0]   count,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [PWM_W-1:0] PERIOD_LAST = PWM_W'(PWM_PERIOD - 1);

  state_t state, state_next;

  logic [NCH-1:0][CNT_W-1:0] target_v, tgt_q, cnt_q, cnt_next, cnt_inc;
  logic [NCH-1:0][PWM_W-1:0] duty_v, duty_q;
  logic [NCH-1:0]            en_next;
  logic                      done_next;
  logic                      load;
  logic [PWM_W-1:0]          pwm_cnt;
  logic [NCH-1:0]            enc_meta, enc_sync, enc_hist, enc_edge;
  logic [NCH-1:0]            hold;

  assign target_v = target;
  assign duty_v   = duty;
  assign count    = cnt_q;
  assign busy     = (state == RUN);
  assign enc_edge = enc_sync & ~enc_hist;

  // Encoder inputs are asynchronous: two flops for metastability, a third to find the rising edge.
  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      enc_meta <= '0;
      enc_sync <= '0;
      enc_hist <= '0;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous stage's old value,
      // which is what turns these three lines into a shift chain rather than one wire.
      enc_meta <= encdr;
      enc_sync <= enc_meta;
      enc_hist <= enc_sync;
    end
  end

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt == PERIOD_LAST) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can leave one
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    en_next    = en;
    cnt_next   = cnt_q;
    done_next  = 1'b0;
    load       = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      cnt_inc[i] = cnt_q[i] + CNT_W'(1);
    end

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          load       = 1'b1;
          state_next = RUN;
          cnt_next   = '0;
          for (int i = 0; i < NCH; i++) begin
            en_next[i] = (target_v[i] != '0);
          end
        end
      end
      RUN: begin
        if (abort) begin
          en_next    = '0;
          state_next = IDLE;
        end else if (en == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          // The edge that reaches the target also drops enable, so count can never pass it.
          for (int i = 0; i < NCH; i++) begin
            if (en[i] && enc_edge[i]) begin
              cnt_next[i] = cnt_inc[i];
              if (cnt_inc[i] == tgt_q[i]) begin
                en_next[i] = 1'b0;
              end
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      en     <= '0;
      cnt_q  <= '0;
      done   <= 1'b0;
      tgt_q  <= '0;
      duty_q <= '0;
      dir    <= '0;
    end else begin
      en    <= en_next;
      cnt_q <= cnt_next;
      done  <= done_next;
      if (load) begin
        tgt_q  <= target_v;
        duty_q <= duty_v;
        dir    <= dir_in;
      end
    end
  end

`ifdef STEPCTL_SYNC_EN
  // A running channel more than SYNC_TOL ticks ahead of the slowest running channel coasts.
  logic [CNT_W:0] min_cnt;

  always_comb begin
    min_cnt = {1'b0, {CNT_W{1'b1}}};
    hold    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (en[i] && ({1'b0, cnt_q[i]} < min_cnt)) begin
        min_cnt = {1'b0, cnt_q[i]};
      end
    end
    for (int i = 0; i < NCH; i++) begin
      hold[i] = en[i] && ({1'b0, cnt_q[i]} > (min_cnt + (CNT_W+1)'(SYNC_TOL)));
    end
  end
`else
  logic [31:0] sync_tol_unused;

  assign sync_tol_unused = 32'(SYNC_TOL);
  assign hold            = '0;
`endif

  always_comb begin
    pwm = '0;
    for (int i = 0; i < NCH; i++) begin
      pwm[i] = en[i] && (pwm_cnt < duty_q[i]) && !hold[i];
    end
  end

endmodule

// File: doc/multi_stepctl.md
# multi_stepctl

Parametrised N-channel closed-loop step controller for the robot drive motors. Each channel runs its motor at a programmed PWM duty and direction until a programmed number of encoder rising edges has been counted, then disables the motor. All channels start together on one start pulse; completion is reported once, when every channel has finished. It replaces per-motor single-channel step controllers at the top level, which adds direction control, abort and progress readback.

## Interface
- NCH, 2, number of motor channels (1..8)
- CNT_W, 16, width of target and tick counters
- PWM_W, 16, width of PWM counter and duty
- PWM_PERIOD, 16'd10000, PWM period in clocks (2..2^PWM_W-1)
- SYNC_TOL, 4, allowed tick lead over slowest active channel (sync feature only)

- WF_CLK  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches targets and begins a move
- abort  in  1  one-cycle pulse; stops all channels immediately
- target  in  NCH*CNT_W  per-channel tick target, channel i at [i*CNT_W +: CNT_W]
- duty  in  NCH*PWM_W  per-channel PWM high time in clocks
- dir_in  in  NCH  per-channel direction
- encdr  in  NCH  raw asynchronous encoder inputs
- pwm  out  NCH  motor PWM
- en  out  NCH  motor enable, high while channel is running
- dir  out  NCH  latched direction
- count  out  NCH*CNT_W  ticks counted in current/last move
- busy  out  1  move in progress
- done  out  1  one-cycle pulse on normal completion

## Operation
- Global FSM: IDLE, RUN.
- IDLE: on start (and no abort): latch target, duty, dir_in; clear all count; en[i]=1 for each channel with target≠0; go to RUN.
- Start while in RUN is ignored. Start and abort in the same cycle: abort wins, stay IDLE.
- RUN: per channel, a synchronised encoder rising edge while en[i]=1 increments count[i]. The clock edge that writes count[i]=target[i] also clears en[i]. Edges with en[i]=0 are ignored; count never exceeds target.
- RUN → IDLE when all en are 0; done pulses high for exactly that one cycle.
- All targets 0: RUN entered with all en=0; done pulses the next cycle.
- abort in RUN: all en cleared, dir held, count frozen, → IDLE, no done.
- PWM: single shared free-running counter 0..PWM_PERIOD-1, wraps to 0. pwm[i] = en[i] & (pwm_cnt < duty[i]). duty ≥ PWM_PERIOD gives constant high; duty 0 gives constant low (channel stays enabled; abort is the only exit).
- Encoder path: 2-flop synchroniser plus one history flop per channel; edge = sync & ~hist.

## Timing
- Reset values: pwm=0, en=0, dir=0, count=0, busy=0, done=0, FSM IDLE, PWM counter 0.
- start sampled at cycle T: en, dir, busy high from T+1.
- Encoder rising input before edge T: count increments at T+3.
- busy = (state==RUN); falls in the same cycle done pulses.
- pwm is combinational from registered en, duty and pwm_cnt; no glitch-free guarantee beyond that.
- Reset asserted mid-move: all outputs return to reset values immediately; no done.

## Configuration
- STEPCTL_SYNC_EN defined: in RUN, for each channel with en[i]=1, if count[i] > (minimum count over channels with en=1) + SYNC_TOL, pwm[i] is forced low (en[i] stays 1) until the lag is within tolerance. Keeps wheels in lockstep for straight driving. Finished channels are excluded from the minimum.
- Not defined: channels run independently; SYNC_TOL unused.

## Test plan
- Reset: assert rst_n=0 mid-RUN → all outputs 0 immediately, no done after release.
- NCH=2, targets 5 and 3, duty 5000, 10 encoder pulses each → en[1] falls on 3rd counted edge, en[0] on 5th, count = 5/3, single done pulse with busy falling that cycle.
- Targets 0,0 with start → busy high one cycle, done pulse at T+2, en never high.
- abort after 2 ticks on target 10 → en=0 next cycle, count=2 frozen, no done; start+abort same cycle in IDLE → no move.
- PWM: duty 0, 2500, 10000 with PWM_PERIOD 10000 → pwm low, 25% high, constant high; extra encoder edges after target do not change count.
- STEPCTL_SYNC_EN, SYNC_TOL=4: pulse channel 0 only → pwm[0] forced low once count[0]=5 with count[1]=0; pulse channel 1 → pwm[0] resumes when count[1]=1.
